// File: rtl/lb_win2x2_if.sv
// Pixel-in / window-out bundle for the 2x2 line-buffer window stage.
// The producer of pixels holds the master side; lb_win2x2 holds the slave side.
interface lb_win2x2_if #(
  parameter int DATA_W = 8
);
  localparam int SUM_W = DATA_W + 2;

  logic [DATA_W-1:0] cur_pix;
  logic              cur_wen;
  logic [DATA_W-1:0] above_pix;
  logic              above_valid;
  logic [SUM_W-1:0]  out_sum;
  logic [DATA_W-1:0] out_avg;
  logic              out_valid;
  logic              out_eol;
  logic              out_eof;

  modport master (
    output cur_pix, cur_wen, above_pix, above_valid,
    input  out_sum, out_avg, out_valid, out_eol, out_eof
  );

  modport slave (
    input  cur_pix, cur_wen, above_pix, above_valid,
    output out_sum, out_avg, out_valid, out_eol, out_eof
  );
endinterface

// File: rtl/lb_win2x2.sv
// Sliding 2x2 window over the current line and the line-buffered line above.
// Emits a registered box sum, rounded average and end-of-line/frame markers.
module lb_win2x2 #(
  parameter int LWIDTH = 8,
  parameter int IMG_H  = 8,
  parameter int DATA_W = 8
) (
  input  logic        CLK,
  input  logic        RESET,
  lb_win2x2_if.slave  s
);

  localparam int SUM_W = DATA_W + 2;
  localparam int COL_W = $clog2(LWIDTH);
  localparam int ROW_W = $clog2(IMG_H);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(LWIDTH - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 2);

  function automatic logic [DATA_W-1:0] round_avg(input logic [SUM_W-1:0] sum);
    logic [SUM_W-1:0] biased;
    biased = sum + SUM_W'(2);
    return biased[SUM_W-1:2];
  endfunction

  logic              acc_p0;
  logic              col_last_p0;
  logic              row_last_p0;

  logic [DATA_W-1:0] tl_q, tl_d, bl_q, bl_d, tr_q, tr_d, br_q, br_d;
  logic [COL_W-1:0]  col_q, col_d;
  logic [ROW_W-1:0]  row_q, row_d;

  logic [SUM_W-1:0]  sum_p1_q, sum_p1_d;
  logic [DATA_W-1:0] avg_p1_q, avg_p1_d;
  logic              vld_p1_q, vld_p1_d;
  logic              eol_p1_q, eol_p1_d;
  logic              eof_p1_q, eof_p1_d;

  // Stage p0: accept, window shift, position counters, window sum
  always_comb begin
    acc_p0      = s.cur_wen & s.above_valid;
    col_last_p0 = (col_q == COL_LAST);
    row_last_p0 = (row_q == ROW_LAST);

    tl_d     = tl_q;
    bl_d     = bl_q;
    tr_d     = tr_q;
    br_d     = br_q;
    col_d    = col_q;
    row_d    = row_q;
    sum_p1_d = sum_p1_q;
    avg_p1_d = avg_p1_q;
    vld_p1_d = 1'b0;
    eol_p1_d = 1'b0;
    eof_p1_d = 1'b0;

    if (acc_p0) begin
      tl_d = tr_q;
      bl_d = br_q;
      tr_d = s.above_pix;
      br_d = s.cur_pix;

      col_d = col_last_p0 ? '0 : col_q + 1'b1;
      if (col_last_p0) begin
        row_d = row_last_p0 ? '0 : row_q + 1'b1;
      end

      // Column 0 still shifts but is masked: its left column belongs to the previous line.
      sum_p1_d = SUM_W'(tl_d) + SUM_W'(bl_d) + SUM_W'(tr_d) + SUM_W'(br_d);
      avg_p1_d = round_avg(sum_p1_d);
      vld_p1_d = (col_q != '0);
      eol_p1_d = col_last_p0;
      eof_p1_d = col_last_p0 & row_last_p0;
    end
  end

  // Stage p1: registered window state and outputs
  always_ff @(posedge CLK) begin
    if (RESET) begin
      tl_q     <= '0;
      bl_q     <= '0;
      tr_q     <= '0;
      br_q     <= '0;
      col_q    <= '0;
      row_q    <= '0;
      sum_p1_q <= '0;
      avg_p1_q <= '0;
      vld_p1_q <= 1'b0;
      eol_p1_q <= 1'b0;
      eof_p1_q <= 1'b0;
    end else begin
      tl_q     <= tl_d;
      bl_q     <= bl_d;
      tr_q     <= tr_d;
      br_q     <= br_d;
      col_q    <= col_d;
      row_q    <= row_d;
      sum_p1_q <= sum_p1_d;
      avg_p1_q <= avg_p1_d;
      vld_p1_q <= vld_p1_d;
      eol_p1_q <= eol_p1_d;
      eof_p1_q <= eof_p1_d;
    end
  end

  assign s.out_sum   = sum_p1_q;
  assign s.out_avg   = avg_p1_q;
  assign s.out_valid = vld_p1_q;
  assign s.out_eol   = eol_p1_q;
  assign s.out_eof   = eof_p1_q;

endmodule

// File: doc/lb_win2x2.md
Name: lb_win2x2

Overview:
- Downstream consumer of the 8-bit, 64-entry line-buffer memory.
- Takes the current-line pixel (same stream fed to the line buffer's write port) and the line-buffered pixel from the row above, then assembles a sliding 2x2 window.
- Emits a registered 2x2 box sum and rounded average per window, plus end-of-line and end-of-frame markers, for the next filter stage.

Parameters:
- LWIDTH, 8, pixels per line; must match the line-buffer delay (2..64).
- IMG_H, 8, lines per frame (>=2); number of window rows per frame is IMG_H-1.

Ports:
- CLK  input  1  clock; all state updates on rising edge.
- RESET  input  1  synchronous, active-high reset.
- cur_pix  input  8  current-line pixel (same value driven to line-buffer wdata).
- cur_wen  input  1  current pixel strobe (same as line-buffer wen).
- above_pix  input  8  pixel one line above (line-buffer rdata).
- above_valid  input  1  line-buffer valid.
- out_sum  output  10  sum of the 4 window pixels.
- out_avg  output  8  (out_sum + 2) >> 2.
- out_valid  output  1  window output qualifier.
- out_eol  output  1  last window of a line; qualified by out_valid.
- out_eof  output  1  last window of a frame; qualified by out_valid.

Behaviour:
- Clock and reset: one clock CLK; reset is synchronous and active-high on RESET.
- Accept: acc = cur_wen & above_valid. Cycles with cur_wen=1 and above_valid=0 are the first line of a frame and are ignored. Cycles with cur_wen=0 (including line-buffer drain cycles with valid=1) are ignored; all state holds.
- Window registers: tl, bl (left column), tr, br (right column), all 8 bits.
  - On acc: tl<=tr, bl<=br, tr<=above_pix, br<=cur_pix.
  - No update otherwise.
- col counter:
  - Width ceil(log2(LWIDTH)).
  - Increments on acc and wraps LWIDTH-1 -> 0.
  - Value before the update is the column index of the accepted pixel.
- row counter:
  - Width ceil(log2(IMG_H)).
  - Increments on acc when col==LWIDTH-1.
  - Wraps IMG_H-2 -> 0.
- Window valid:
  - A window is produced on acc with col!=0, i.e. the left column comes from the same line.
  - col==0 never produces output, so there is no window straddling the line wrap.
- Output pipeline: 1-cycle latency, with registered outputs on the edge following the acc cycle.
  - out_valid <= acc & (col!=0), i.e. a single-cycle pulse per window.
  - out_sum <= zero-extended tr_old + br_old + above_pix + cur_pix, where tr_old/br_old are the values before the shift. Max value 1020; no overflow.
  - out_avg <= (sum+2)>>2, computed on the 10-bit sum (max 1022 before shift), truncated to 8 bits. Max value 255.
  - out_eol <= acc & (col==LWIDTH-1).
  - out_eof <= acc & (col==LWIDTH-1) & (row==IMG_H-2).
  - When not acc: out_valid, out_eol and out_eof go to 0 next cycle; out_sum and out_avg hold their last values.
- Per frame: LWIDTH-1 windows per line; (LWIDTH-1)*(IMG_H-1) windows per frame.
- Frame wrap: after out_eof, col=0 and row=0. The next accepted pixel starts a new frame's first window row. Window registers are not cleared; col==0 masks stale data.
- Reset values: all outputs 0, col=0, row=0, window registers 0.
- Reset mid-operation: RESET dominates acc in the same cycle. Everything returns to reset values next edge and any in-flight window is discarded.
- Stalls: gaps in acc of any length are transparent. A window spanning a gap is still correct because the registers hold.

Test Plan:
- Reset with constant inputs (LWIDTH=8, IMG_H=8): hold RESET 2 cycles while cur_wen=1, above_valid=1, pixels=0xFF -> all outputs 0; after release, first out_valid appears on the 2nd acc, +1 cycle, with out_sum=1020, out_avg=255.
- Full frame, above_pix=row index, cur_pix=row index+1 (line 0 supplies only cur_wen, above_valid=0) -> exactly 7 out_valid per line and 49 per frame; out_eol on each 7th; single out_eof on the 49th; line-1 windows give out_sum=2, out_avg=1 (sum=2: (2+2)>>2=1).
- Rounding: window pixels 1,1,1,0 -> out_sum=3, out_avg=1; pixels 1,1,0,0 -> out_sum=2, out_avg=1; pixels 1,0,0,0 -> out_sum=1, out_avg=0.
- Stall/drain: insert 5 cycles of cur_wen=0, above_valid=1 mid-line (col=3) -> no outputs and no counter change; the next window sums the pre-stall right column plus the new pixels correctly, and the column count ends at 7 windows for the line.
- Line wrap: tr/br hold 200 at col=7; next line's col=0 pixels are 10 -> no out_valid for col=0; the col=1 window sums only the new line's pixels.
- Mid-frame reset at row=3, col=5 with acc=1 in the same cycle -> no output pulse; col=0 and row=0; the following frame produces 49 windows and one out_eof at the correct position.
